// File: rtl/seg7_pkg.sv
// Shared types and segment pattern constants for the seven-segment reader.
// Patterns are written g..a (bit6 = g, bit0 = a), active-low.
package seg7_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;

    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [CODE_W-1:0] code_t;

    localparam seg_t SEG_0 = 7'b1000000;
    localparam seg_t SEG_1 = 7'b1111001;
    localparam seg_t SEG_2 = 7'b0100100;
    localparam seg_t SEG_3 = 7'b0110000;
    localparam seg_t SEG_4 = 7'b0011001;
    localparam seg_t SEG_5 = 7'b0010010;
    localparam seg_t SEG_6 = 7'b0000010;
    localparam seg_t SEG_7 = 7'b1111000;
    localparam seg_t SEG_E = 7'b0000110;

    // Extended hex glyphs, only recognised when the hex decode option is built in.
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0010000;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b0000011;
    localparam seg_t SEG_C = 7'b1000110;
    localparam seg_t SEG_D = 7'b0100001;
    localparam seg_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to code decoder.
// Build option: SEG7_READER_HEX_EN adds the 8, 9, A, b, C, d, F glyphs.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]  seg,
    output logic [CODE_W-1:0] code,
    output logic              known
);

    // Table lookup; anything not listed is reported as unknown with code 0.
    always_comb begin
        code  = '0;
        known = 1'b1;
        case (seg)
            SEG_0:   code = 4'h0;
            SEG_1:   code = 4'h1;
            SEG_2:   code = 4'h2;
            SEG_3:   code = 4'h3;
            SEG_4:   code = 4'h4;
            SEG_5:   code = 4'h5;
            SEG_6:   code = 4'h6;
            SEG_7:   code = 4'h7;
            SEG_E:   code = 4'hE;
`ifdef SEG7_READER_HEX_EN
            SEG_8:   code = 4'h8;
            SEG_9:   code = 4'h9;
            SEG_A:   code = 4'hA;
            SEG_B:   code = 4'hB;
            SEG_C:   code = 4'hC;
            SEG_D:   code = 4'hD;
            SEG_F:   code = 4'hF;
`endif
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Recovers per-digit codes from a multiplexed active-low seven-segment bus.
// A digit commits once its decoded code has been seen STABLE_CNT times in a row.
// Build option: SEG7_READER_HEX_EN (passed through to the pattern decoder).
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEG_W-1:0]         seg_in,
    input  logic [DIGITS-1:0]        an_in,
    input  logic                     sample_en,
    output logic [CODE_W*DIGITS-1:0] value,
    output logic [DIGITS-1:0]        valid,
    output logic                     upd,
    output logic                     pat_err,
    output logic                     sel_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned LOW_W = 4;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CNT - 1);

    logic [CODE_W-1:0] dec_code;
    logic              dec_known;
    logic [LOW_W-1:0]  low_cnt;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_ok;

    logic [CODE_W-1:0] cand_q [DIGITS];
    logic [CNT_W-1:0]  cnt_q  [DIGITS];
    logic [CODE_W-1:0] val_q  [DIGITS];

    seg7_pattern_decode u_decode (
        .seg   (seg_in),
        .code  (dec_code),
        .known (dec_known)
    );

    // Count low select lines and capture which digit is addressed.
    always_comb begin
        low_cnt = '0;
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_in[i]) begin
                low_cnt = low_cnt + LOW_W'(1);
                sel_idx = IDX_W'(i);
            end
        end
        sel_ok = (low_cnt == LOW_W'(1));
    end

    // Per-digit stability tracking, commit and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            upd     <= 1'b0;
            pat_err <= 1'b0;
            sel_err <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                cand_q[i] <= '0;
                cnt_q[i]  <= '0;
                val_q[i]  <= '0;
            end
        end else begin
            upd     <= 1'b0;
            pat_err <= 1'b0;
            sel_err <= 1'b0;
            if (sample_en) begin
                if (!sel_ok) begin
                    sel_err <= 1'b1;
                end else if (!dec_known) begin
                    cnt_q[sel_idx] <= '0;
                    valid[sel_idx] <= 1'b0;
                    pat_err        <= 1'b1;
                end else if (dec_code == cand_q[sel_idx]) begin
                    if (cnt_q[sel_idx] != CNT_MAX) begin
                        cnt_q[sel_idx] <= cnt_q[sel_idx] + CNT_W'(1);
                    end
                    // Commit only on the edge into saturation, never while parked there.
                    if (cnt_q[sel_idx] == CNT_PRE) begin
                        val_q[sel_idx] <= cand_q[sel_idx];
                        valid[sel_idx] <= 1'b1;
                        upd            <= 1'b1;
                    end
                end else begin
                    cand_q[sel_idx] <= dec_code;
                    cnt_q[sel_idx]  <= CNT_W'(1);
                end
            end
        end
    end

    // Flatten committed codes onto the output bus, digit i at [4i+3:4i].
    for (genvar g = 0; g < DIGITS; g++) begin : g_value
        assign value[CODE_W*g +: CODE_W] = val_q[g];
    end

endmodule
